// File: rtl/i2c_eeprom_slave.sv
`default_nettype none
//==============================================================================
// Module   : i2c_eeprom_slave
// Function : Two-wire serial EEPROM responder holding a 2^ADDR_W x 8 array.
//            SCL/SDA are oversampled on CLK; SDA is only pulled low or released.
// Revision : 1.0  initial release
//==============================================================================
module i2c_eeprom_slave #(
   parameter logic [3:0] DEV_CODE = 4'b1010,
   parameter int         ADDR_W   = 11
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              SCL,
   inout  wire               SDA,
   output logic              BUSY,
   output logic              WR_STB,
   output logic [ADDR_W-1:0] WR_ADDR,
   output logic [7:0]        WR_DATA
);
   localparam int HI_W  = ADDR_W - 8;
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_CTRL      = 4'd1,
      ST_CTRL_ACK  = 4'd2,
      ST_ADDR      = 4'd3,
      ST_ADDR_ACK  = 4'd4,
      ST_WDATA     = 4'd5,
      ST_WDATA_ACK = 4'd6,
      ST_RDATA     = 4'd7,
      ST_RDATA_ACK = 4'd8,
      ST_IGNORE    = 4'd9
   } state_t;

   state_t            state_q, state_d;
   logic              scl_s1_q, scl_s2_q, scl_h_q;
   logic              sda_s1_q, sda_s2_q, sda_h_q;
   logic [3:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]        sr_q, sr_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              ph_q, ph_d;
   logic              oe_q, oe_d;
   logic              busy_q, busy_d;
   logic              wr_stb_q, wr_stb_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        wr_data_q, wr_data_d;
   logic              mem_we;
   logic [7:0]        mem_q [DEPTH];

   logic              scl_rise, scl_fall, start_det, stop_det, last_bit;
   logic [7:0]        byte_in, rd_cur, rd_next;
   logic [ADDR_W-1:0] ptr_inc;

   assign scl_rise  = scl_s2_q & ~scl_h_q;
   assign scl_fall  = ~scl_s2_q & scl_h_q;
   assign start_det = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
   assign stop_det  = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
   assign byte_in   = {sr_q[6:0], sda_s2_q};
   assign last_bit  = (bit_cnt_q == 4'd7);
   assign ptr_inc   = ptr_q + 1'b1;
   assign rd_cur    = mem_q[ptr_q];
   assign rd_next   = mem_q[ptr_inc];

   // Open-drain pad: oe_q is async-reset so RESET releases SDA at once.
   assign SDA     = oe_q ? 1'b0 : 1'bz;
   assign BUSY    = busy_q;
   assign WR_STB  = wr_stb_q;
   assign WR_ADDR = wr_addr_q;
   assign WR_DATA = wr_data_q;

   // Two-flop synchronizers plus a history flop per pin; idle bus level is high.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         scl_s1_q <= 1'b1;
         scl_s2_q <= 1'b1;
         scl_h_q  <= 1'b1;
         sda_s1_q <= 1'b1;
         sda_s2_q <= 1'b1;
         sda_h_q  <= 1'b1;
      end else begin
         scl_s1_q <= SCL;
         scl_s2_q <= scl_s1_q;
         scl_h_q  <= scl_s2_q;
         sda_s1_q <= SDA;
         sda_s2_q <= sda_s1_q;
         sda_h_q  <= sda_s2_q;
      end
   end

   // Protocol state register and all registered outputs.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= 4'd0;
         sr_q      <= 8'd0;
         ptr_q     <= '0;
         ph_q      <= 1'b0;
         oe_q      <= 1'b0;
         busy_q    <= 1'b0;
         wr_stb_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         sr_q      <= sr_d;
         ptr_q     <= ptr_d;
         ph_q      <= ph_d;
         oe_q      <= oe_d;
         busy_q    <= busy_d;
         wr_stb_q  <= wr_stb_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   // Storage array; contents survive reset on purpose.
   always_ff @(posedge CLK) begin
      if (mem_we) begin
         mem_q[ptr_q] <= byte_in;
      end
   end

   // Next-state logic. In the driven-ACK states oe_q doubles as the phase bit:
   // the first SCL fall starts the ACK, the second one ends the 9th clock.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      sr_d      = sr_q;
      ptr_d     = ptr_q;
      ph_d      = ph_q;
      oe_d      = oe_q;
      wr_stb_d  = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      mem_we    = 1'b0;

      if (start_det) begin
         state_d   = ST_CTRL;
         bit_cnt_d = 4'd0;
         oe_d      = 1'b0;
         ph_d      = 1'b0;
      end else if (stop_det) begin
         state_d = ST_IDLE;
         oe_d    = 1'b0;
         ph_d    = 1'b0;
      end else begin
         case (state_q)
            ST_CTRL: begin
               if (scl_rise) begin
                  sr_d      = byte_in;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (last_bit) begin
                     bit_cnt_d = 4'd0;
                     if (byte_in[7:4] == DEV_CODE) begin
                        state_d = ST_CTRL_ACK;
                        ptr_d   = {byte_in[HI_W:1], ptr_q[7:0]};
                     end else begin
                        state_d = ST_IGNORE;
                     end
                  end
               end
            end
            ST_CTRL_ACK: begin
               if (scl_fall) begin
                  if (!oe_q) begin
                     oe_d = 1'b1;
                  end else if (sr_q[0]) begin
                     state_d = ST_RDATA;
                     sr_d    = rd_cur;
                     oe_d    = ~rd_cur[7];
                  end else begin
                     state_d = ST_ADDR;
                     oe_d    = 1'b0;
                  end
               end
            end
            ST_ADDR, ST_WDATA: begin
               if (scl_rise) begin
                  sr_d      = byte_in;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (last_bit) begin
                     bit_cnt_d = 4'd0;
                     if (state_q == ST_ADDR) begin
                        state_d = ST_ADDR_ACK;
                        ptr_d   = {ptr_q[ADDR_W-1:8], byte_in};
                     end else begin
                        state_d   = ST_WDATA_ACK;
                        mem_we    = 1'b1;
                        wr_stb_d  = 1'b1;
                        wr_addr_d = ptr_q;
                        wr_data_d = byte_in;
                     end
                  end
               end
            end
            ST_ADDR_ACK, ST_WDATA_ACK: begin
               if (scl_fall) begin
                  if (!oe_q) begin
                     oe_d = 1'b1;
                  end else begin
                     oe_d    = 1'b0;
                     state_d = ST_WDATA;
                     if (state_q == ST_WDATA_ACK) begin
                        ptr_d = ptr_inc;
                     end
                  end
               end
            end
            ST_RDATA: begin
               if (scl_rise) begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     oe_d      = 1'b0;
                     bit_cnt_d = 4'd0;
                     ph_d      = 1'b0;
                     state_d   = ST_RDATA_ACK;
                  end else begin
                     sr_d = {sr_q[6:0], 1'b0};
                     oe_d = ~sr_q[6];
                  end
               end
            end
            ST_RDATA_ACK: begin
               if (scl_rise) begin
                  if (sda_s2_q) begin
                     state_d = ST_IGNORE;
                  end else begin
                     ph_d = 1'b1;
                  end
               end else if (scl_fall && ph_q) begin
                  ph_d    = 1'b0;
                  ptr_d   = ptr_inc;
                  sr_d    = rd_next;
                  oe_d    = ~rd_next[7];
                  state_d = ST_RDATA;
               end
            end
            ST_IDLE, ST_IGNORE: begin
            end
            default: begin
               state_d = ST_IDLE;
               oe_d    = 1'b0;
            end
         endcase
      end

      busy_d = (state_d != ST_IDLE) && (state_d != ST_IGNORE);
   end

endmodule
`default_nettype wire

// File: tb/tb_i2c_eeprom_slave.sv
`default_nettype none
//==============================================================================
// Module   : tb_i2c_eeprom_slave
// Function : Directed bench for i2c_eeprom_slave: bit-banged master, write and
//            read-data scoreboards, open-drain bus with pull-up.
// Revision : 1.0  initial release
//==============================================================================
module tb_i2c_eeprom_slave;
   logic        clk;
   logic        rst;
   logic        scl;
   logic        m_low;
   wire         sda;
   logic        busy;
   logic        wr_stb;
   logic [10:0] wr_addr;
   logic [7:0]  wr_data;

   int          total = 0;
   int          bad   = 0;
   logic [18:0] exp_wr[$];
   logic [7:0]  exp_rd[$];
   logic        stb_prev = 1'b0;
   logic        watch = 1'b0;
   logic        drove = 1'b0;
   logic        ack;
   logic [7:0]  d;

   pullup (sda);
   assign sda = m_low ? 1'b0 : 1'bz;

   i2c_eeprom_slave #(.DEV_CODE(4'b1010), .ADDR_W(11)) dut (
      .CLK    (clk),
      .RESET  (rst),
      .SCL    (scl),
      .SDA    (sda),
      .BUSY   (busy),
      .WR_STB (wr_stb),
      .WR_ADDR(wr_addr),
      .WR_DATA(wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Write-commit scoreboard and strobe-width check, sampled on the falling edge.
   always @(negedge clk) begin
      if (wr_stb) begin
         chk("wr_stb_width", {31'd0, stb_prev}, 32'd0);
         if (exp_wr.size() == 0) begin
            chk("wr_unexpected", exp_wr.size(), 32'd1);
         end else begin
            logic [18:0] e;
            e = exp_wr.pop_front();
            chk("wr_addr", {21'd0, wr_addr}, {21'd0, e[18:8]});
            chk("wr_data", {24'd0, wr_data}, {24'd0, e[7:0]});
         end
      end
      stb_prev = wr_stb;
      if (watch && !m_low && sda === 1'b0) drove = 1'b1;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clk_bit(input logic b, output logic s);
      tick(4); m_low = ~b;
      tick(4); scl = 1'b1;
      tick(6); s = sda;
      tick(2); scl = 1'b0;
   endtask

   task automatic i2c_start();
      if (scl == 1'b0) begin
         tick(4); m_low = 1'b0;
         tick(4); scl = 1'b1;
      end
      tick(8); m_low = 1'b1;
      tick(8); scl = 1'b0;
   endtask

   task automatic i2c_stop();
      tick(4); m_low = 1'b1;
      tick(4); scl = 1'b1;
      tick(8); m_low = 1'b0;
      tick(8);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic a);
      logic s;
      for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
      clk_bit(1'b1, a);
   endtask

   task automatic read_byte(input logic nack);
      logic s;
      logic [7:0] got;
      got = 8'd0;
      for (int i = 0; i < 8; i++) begin
         clk_bit(1'b1, s);
         got = {got[6:0], s};
      end
      clk_bit(nack, s);
      if (exp_rd.size() == 0) chk("rd_unexpected", exp_rd.size(), 32'd1);
      else chk("rd_data", {24'd0, got}, {24'd0, exp_rd.pop_front()});
   endtask

   // START, write control byte and address byte, leaving the bus mid-transfer.
   task automatic set_addr(input logic [10:0] a);
      logic k;
      i2c_start();
      write_byte({4'hA, a[10:8], 1'b0}, k);
      chk("ack_ctrl_w", {31'd0, k}, 32'd0);
      write_byte(a[7:0], k);
      chk("ack_addr", {31'd0, k}, 32'd0);
   endtask

   task automatic read_ctrl(input logic [2:0] hi);
      logic k;
      i2c_start();
      write_byte({4'hA, hi, 1'b1}, k);
      chk("ack_ctrl_r", {31'd0, k}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; scl = 1'b1; m_low = 1'b0;
      tick(3);
      chk("rst_sda", {31'd0, sda}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_wr_stb", {31'd0, wr_stb}, 32'd0);
      chk("rst_wr_addr", {21'd0, wr_addr}, 32'd0);
      chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
      rst = 1'b0;
      tick(10);

      // Byte write 0x5A to 0x123.
      exp_wr.push_back({11'h123, 8'h5A});
      set_addr(11'h123);
      chk("busy_in_xfer", {31'd0, busy}, 32'd1);
      write_byte(8'h5A, ack);
      chk("ack_data", {31'd0, ack}, 32'd0);
      i2c_stop();
      chk("busy_after_stop", {31'd0, busy}, 32'd0);
      chk("wr_pending_1", exp_wr.size(), 32'd0);

      // Random read back from 0x123.
      set_addr(11'h123);
      read_ctrl(3'd1);
      exp_rd.push_back(8'h5A);
      read_byte(1'b1);
      i2c_stop();
      chk("rd_sda_released", {31'd0, sda}, 32'd1);
      chk("rd_busy_idle", {31'd0, busy}, 32'd0);

      // Sequential write across the top of the array, then sequential read.
      exp_wr.push_back({11'h7FF, 8'h11});
      exp_wr.push_back({11'h000, 8'h22});
      set_addr(11'h7FF);
      write_byte(8'h11, ack);
      chk("ack_seq_w0", {31'd0, ack}, 32'd0);
      write_byte(8'h22, ack);
      chk("ack_seq_w1", {31'd0, ack}, 32'd0);
      i2c_stop();
      chk("wr_pending_2", exp_wr.size(), 32'd0);
      set_addr(11'h7FF);
      read_ctrl(3'd7);
      exp_rd.push_back(8'h11);
      exp_rd.push_back(8'h22);
      read_byte(1'b0);
      read_byte(1'b1);
      i2c_stop();

      // Wrong device code: no ACK, no drive, no commit.
      i2c_start();
      drove = 1'b0;
      watch = 1'b1;
      write_byte(8'h92, ack);
      chk("nack_wrong_dev", {31'd0, ack}, 32'd1);
      write_byte(8'h00, ack);
      watch = 1'b0;
      chk("ignore_no_ack", {31'd0, ack}, 32'd1);
      chk("ignore_no_drive", {31'd0, drove}, 32'd0);
      i2c_stop();

      // Abort after 5 data bits: nothing committed, old value still readable.
      set_addr(11'h123);
      for (int i = 7; i >= 3; i--) begin
         logic s;
         logic [7:0] pat;
         pat = 8'hA5;
         clk_bit(pat[i], s);
      end
      i2c_stop();
      chk("abort_busy", {31'd0, busy}, 32'd0);
      set_addr(11'h123);
      read_ctrl(3'd1);
      exp_rd.push_back(8'h5A);
      read_byte(1'b1);
      i2c_stop();

      // Reset while the slave drives bit 7 (a 0) of 0x5A.
      set_addr(11'h123);
      read_ctrl(3'd1);
      tick(6);
      chk("rd_bit7_low", {31'd0, sda}, 32'd0);
      rst = 1'b1;
      #1;
      chk("midrst_sda", {31'd0, sda}, 32'd1);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_wr_addr", {21'd0, wr_addr}, 32'd0);
      chk("midrst_wr_data", {24'd0, wr_data}, 32'd0);
      tick(2);
      scl = 1'b1; m_low = 1'b0;
      tick(4);
      rst = 1'b0;
      tick(8);
      exp_wr.push_back({11'h005, 8'h77});
      set_addr(11'h005);
      write_byte(8'h77, ack);
      chk("ack_after_rst", {31'd0, ack}, 32'd0);
      i2c_stop();
      tick(4);
      chk("wr_pending_end", exp_wr.size(), 32'd0);
      chk("rd_pending_end", exp_rd.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/i2c_eeprom_slave.md
# i2c_eeprom_slave

Synthesizable responder for the two-wire serial EEPROM protocol. It holds a 2K×8 array and answers byte writes and reads on SCL/SDA, with 11-bit addressing: A[10:8] in the control byte, A[7:0] in the address byte. It is the device-side counterpart of the EEPROM read/write master. It serves as that master's bench target and as an on-chip EEPROM emulator. SCL and SDA are oversampled with the system clock; SDA is only ever driven low or released.

## Interface
- DEV_CODE, 4'b1010, device-type code expected in control byte bits [7:4]
- ADDR_W, 11, memory address width; depth = 2^ADDR_W
- CLK  input  1  system clock, must be ≥ 8× SCL frequency
- RESET  input  1  asynchronous, active-high reset
- SCL  input  1  serial clock from master
- SDA  inout  1  serial data; driven 0 or z only (external pull-up)
- BUSY  output  1  high from START until STOP or abandon
- WR_STB  output  1  one-CLK pulse when a data byte is committed to memory
- WR_ADDR  output  ADDR_W  address of committed byte
- WR_DATA  output  8  committed byte

## Operation
- Input conditioning: SCL and SDA each pass through a 2-flop synchronizer plus one history flop; rise/fall detected on synced values.
- START: SDA falls while SCL high. Legal in any state, including repeated start. Clears the bit counter and goes to CTRL.
- STOP: SDA rises while SCL high. Legal in any state. Goes to IDLE, releases SDA and drops BUSY. A partial byte is discarded and never written.
- Bits are sampled on SCL rise, MSB first. SDA drive changes only on SCL fall.
- States and transitions:
  - IDLE: wait for START.
  - CTRL: shift 8 bits.
    - If [7:4]==DEV_CODE, then go to CTRL_ACK, latching A[10:8] and R/W.
    - Otherwise go to IGNORE (no ACK).
  - CTRL_ACK: drive 0 for the 9th clock.
    - R/W=0: go to ADDR.
    - R/W=1: load mem[ptr] into the shift register and go to RDATA.
  - ADDR: shift 8 bits, then go to ADDR_ACK. ptr = {A[10:8], byte}.
  - ADDR_ACK: drive 0, then go to WDATA.
  - WDATA: shift 8 bits. On the 8th rising sample:
    - write mem[ptr];
    - pulse WR_STB with WR_ADDR=ptr and WR_DATA=byte;
    - go to WDATA_ACK.
  - WDATA_ACK: drive 0. ptr = ptr+1 modulo 2^ADDR_W. Go to WDATA for sequential write.
  - RDATA: drive SDA = 0 if the current bit is 0, z if it is 1. Bit 7 is presented at the SCL fall that ends CTRL_ACK or RDATA_ACK. After 8 bits, release and go to RDATA_ACK.
  - RDATA_ACK: sample the master's bit.
    - 0 (ACK): ptr+1 modulo 2^ADDR_W, load next byte, go to RDATA.
    - 1 (NACK): go to IGNORE.
  - IGNORE: SDA released. Wait for START or STOP.
- A repeated START after ADDR_ACK, followed by a read control byte, gives a random read. It keeps the ptr set by the address byte, with A[10:8] overwritten by the new control byte.
- Memory contents are not reset. Only state, ptr and outputs are reset.

## Timing
- Reset values:
  - SDA = z
  - BUSY = 0
  - WR_STB = 0
  - WR_ADDR = 0
  - WR_DATA = 0
  - ptr = 0
  - state = IDLE
- Reset asserted mid-transfer releases SDA immediately (asynchronously); no write occurs.
- Pin-to-detect latency: 3 CLK from pin change to the edge or START/STOP event.
- ACK drive: SDA goes low 1 CLK after the detected SCL fall that ends bit 8. It is released 1 CLK after the detected SCL fall that ends the 9th clock.
- WR_STB is asserted the CLK after the 8th data-bit sample, for exactly 1 CLK. WR_ADDR/WR_DATA hold until the next commit.
- START/STOP detection takes priority over a simultaneous SCL edge in the same CLK.
- Required setup: SCL high and low phases ≥ 4 CLK each. SDA changes by the master must occur ≥ 3 CLK away from SCL rise.

## Test plan
- Byte write: START, 0xA2 (A[10:8]=1), 0x23, 0x5A, STOP -> ACK on all three bytes; WR_STB once with WR_ADDR=0x123, WR_DATA=0x5A; BUSY 0 after STOP.
- Random read: after the write above, START, 0xA2, 0x23, repeated START, 0xA3 -> slave returns 0x5A MSB first; master NACK, then STOP -> SDA released, state IDLE.
- Sequential wrap: write 0x11, 0x22 starting at 0x7FF -> commits at 0x7FF then 0x000. A sequential read from 0x7FF with ACK, then NACK, returns 0x11, 0x22.
- Wrong device code: START, 0x92 -> no ACK (SDA stays z for all 9 clocks); no WR_STB until the next START.
- Abort: STOP after 5 bits of the data byte -> no WR_STB, memory unchanged. A read-back of that address returns the old value.
- Reset mid-read: assert RESET while the slave drives a 0 bit -> SDA z in the same cycle, all outputs at reset values, next START accepted normally.
